// File: rtl/perf_sampler.sv
// perf_sampler: periodically sweeps the 64 perf monitor counter words into a
// local snapshot RAM, optionally clears the links afterwards, and exposes the
// snapshot plus CTRL/PERIOD/SEQ/STATUS to the host over a zero-wait slave.
// Build macro PERF_SAMPLER_DBUF_EN: double-buffered snapshot with bank swap on
// sample commit; STATUS bit2 then reports the front bank.
module perf_sampler #(
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [5:0]  perf_address,
  output logic        perf_read,
  output logic        perf_write,
  output logic [31:0] perf_writedata,
  input  logic [31:0] perf_readdata,
  input  logic [6:0]  host_address,
  input  logic        host_read,
  input  logic        host_write,
  input  logic [31:0] host_writedata,
  output logic [31:0] host_readdata
);

  localparam logic [6:0] AddrCtrl   = 7'h40;
  localparam logic [6:0] AddrPeriod = 7'h41;
  localparam logic [6:0] AddrSeq    = 7'h42;
  localparam logic [6:0] AddrStatus = 7'h43;
  localparam logic [5:0] LastIdx    = 6'(NUM_REGS - 1);
  localparam logic [5:0] LastLink   = 6'd3;

`ifdef PERF_SAMPLER_DBUF_EN
  localparam int unsigned Banks  = 2;
  localparam int unsigned SnapAw = 7;
`else
  localparam int unsigned Banks  = 1;
  localparam int unsigned SnapAw = 6;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSweep,
    StClear,
    StDone,
    StWait
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q;
  logic                en_q, clr_q, trig_q, ovr_q;
  logic [31:0]         seq_q;
  logic                busy;
  logic                ctrl_wr, period_wr, status_wr;
  logic                front_bank;
  logic [SnapAw-1:0]   snap_waddr, snap_raddr;
  logic [31:0]         rd_data;
  logic                unused_wdata;

  logic [31:0] snap_mem [Banks*NUM_REGS];

  assign ctrl_wr        = host_write && (host_address == AddrCtrl);
  assign period_wr      = host_write && (host_address == AddrPeriod);
  assign status_wr      = host_write && (host_address == AddrStatus);
  assign busy           = (state_q == StSweep) || (state_q == StClear);
  assign perf_writedata = '0;
  assign unused_wdata   = ^host_writedata;

`ifdef PERF_SAMPLER_DBUF_EN
  logic bank_q;

  // Swap front/back banks in the same cycle the sample is committed (SEQ++).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else if (state_q == StDone) begin
      bank_q <= ~bank_q;
    end
  end

  assign front_bank = bank_q;
  assign snap_waddr = {~bank_q, idx_q};
  assign snap_raddr = {bank_q, host_address[5:0]};
`else
  assign front_bank = 1'b0;
  assign snap_waddr = idx_q;
  assign snap_raddr = host_address[5:0];
`endif

  // Control/status registers; TRIG is held for exactly one cycle after its write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      trig_q   <= 1'b0;
      period_q <= '0;
      seq_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      trig_q <= ctrl_wr && host_writedata[2];
      if (ctrl_wr) begin
        en_q  <= host_writedata[0];
        clr_q <= host_writedata[1];
      end
      if (period_wr) begin
        period_q <= host_writedata[PERIOD_W-1:0];
      end
      if (state_q == StDone) begin
        seq_q <= seq_q + 32'd1;
      end
      // A dropped trigger wins over a simultaneous STATUS clear.
      if (trig_q && busy) begin
        ovr_q <= 1'b1;
      end else if (status_wr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: sweep, optional link clear, commit, inter-sample wait.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en_q || trig_q) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = clr_q ? StClear : StDone;
        end
      end
      StClear: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LastLink) begin
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        idx_d = '0;
        if (trig_q || (en_q && (period_q == '0))) begin
          state_d = StSweep;
        end else if (en_q) begin
          state_d = StWait;
          cnt_d   = period_q;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        idx_d = '0;
        if (trig_q) begin
          state_d = StSweep;
        end else if (!en_q) begin
          state_d = StIdle;
        end else if (cnt_q <= PERIOD_W'(1)) begin
          state_d = StSweep;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Monitor strobes decode straight from state so reset drops them at once.
  always_comb begin
    perf_read    = 1'b0;
    perf_write   = 1'b0;
    perf_address = '0;
    if (state_q == StSweep) begin
      perf_read    = 1'b1;
      perf_address = idx_q;
    end else if (state_q == StClear) begin
      perf_write   = 1'b1;
      perf_address = {idx_q[1:0], 4'b0000};
    end
  end

  // Snapshot capture; not reset, contents valid only after the first sweep.
  always_ff @(posedge clk) begin
    if (perf_read) begin
      snap_mem[snap_waddr] <= perf_readdata;
    end
  end

  // Host read mux; snapshot reads see the pre-write value on a same-index collision.
  always_comb begin
    rd_data = '0;
    if (!host_address[6]) begin
      rd_data = snap_mem[snap_raddr];
    end else begin
      case (host_address)
        AddrCtrl:   rd_data = {30'b0, clr_q, en_q};
        AddrPeriod: rd_data = 32'(period_q);
        AddrSeq:    rd_data = seq_q;
        AddrStatus: rd_data = {29'b0, front_bank, ovr_q, busy};
        default:    rd_data = '0;
      endcase
    end
  end

  // Registered host read data, one cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_readdata <= '0;
    end else if (host_read) begin
      host_readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_perf_sampler.sv
// tb_perf_sampler: randomized self-checking bench for perf_sampler with a
// sample-level reference model and a per-cycle compare process.
module tb_perf_sampler;

  localparam logic [6:0] AddrCtrl   = 7'h40;
  localparam logic [6:0] AddrPeriod = 7'h41;
  localparam logic [6:0] AddrSeq    = 7'h42;
  localparam logic [6:0] AddrStatus = 7'h43;
`ifdef PERF_SAMPLER_DBUF_EN
  localparam bit Dbuf = 1'b1;
`else
  localparam bit Dbuf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  perf_address;
  logic        perf_read, perf_write;
  logic [31:0] perf_writedata, perf_readdata;
  logic [6:0]  host_address = '0;
  logic        host_read = 1'b0;
  logic        host_write = 1'b0;
  logic [31:0] host_writedata = '0;
  logic [31:0] host_readdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_sampler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .perf_address   (perf_address),
    .perf_read      (perf_read),
    .perf_write     (perf_write),
    .perf_writedata (perf_writedata),
    .perf_readdata  (perf_readdata),
    .host_address   (host_address),
    .host_read      (host_read),
    .host_write     (host_write),
    .host_writedata (host_writedata),
    .host_readdata  (host_readdata)
  );

  // Monitor environment: value = 0x1000 + addr, tagged with the sweep number in [31:16].
  logic [15:0] mon_tag = '0;
  assign perf_readdata = {mon_tag, 16'h0000} + 32'h0000_1000 + {26'b0, perf_address};
  always @(posedge clk) if (perf_read && perf_address == 6'd63) mon_tag <= mon_tag + 16'd1;

  // Reference model: sample-level view (offset inside a strobe run, wait countdown).
  bit          m_active = 0;
  int          m_off = 0;
  bit          m_done = 0;
  int          m_wait = 0;
  int          m_started = 0;
  int          m_cur = 0;
  int          m_front = 0;
  bit          m_en = 0, m_clr = 0, m_trig = 0, m_ovr = 0;
  logic [23:0] m_period = '0;
  logic [31:0] m_seq = '0;
  logic [31:0] m_snap [2][64];
  bit          m_val [2][64];
  bit          exp_pend = 0, exp_ok = 0;
  logic [31:0] exp_val = '0;

  initial begin : model
    bit busy_now, start;
    int wb;
    @(posedge rst_n);
    forever begin
      @(posedge clk);
      busy_now = m_active;
      if (host_read) begin
        exp_pend = 1;
        exp_ok   = 1;
        exp_val  = '0;
        if (host_address < 7'h40) begin
          exp_ok  = m_val[m_front][host_address[5:0]];
          exp_val = m_snap[m_front][host_address[5:0]];
        end else if (host_address == AddrCtrl) begin
          exp_val = {30'b0, m_clr, m_en};
        end else if (host_address == AddrPeriod) begin
          exp_val = {8'b0, m_period};
        end else if (host_address == AddrSeq) begin
          exp_val = m_seq;
        end else if (host_address == AddrStatus) begin
          exp_val = {29'b0, (Dbuf && m_front == 1), m_ovr, busy_now};
        end
      end
      wb = Dbuf ? 1 - m_front : 0;
      if (m_active && m_off < 64) begin
        m_snap[wb][m_off] = 32'h1000 + 32'(m_off) + ((32'(m_cur) & 32'hFFFF) << 16);
        m_val[wb][m_off]  = 1;
      end
      start = 0;
      if (m_active) begin
        m_off++;
        if ((m_off == 64 && !m_clr) || m_off == 68) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (m_done) begin
        m_done = 0;
        m_seq  = m_seq + 32'd1;
        if (Dbuf) m_front = 1 - m_front;
        if (m_trig) start = 1;
        else if (m_en && m_period == 0) start = 1;
        else if (m_en) m_wait = int'(m_period);
      end else if (m_wait > 0) begin
        if (m_trig || (m_en && m_wait == 1)) begin
          start  = 1;
          m_wait = 0;
        end else if (!m_en) begin
          m_wait = 0;
        end else begin
          m_wait--;
        end
      end else if (m_en || m_trig) begin
        start = 1;
      end
      if (start) begin
        m_active = 1;
        m_off    = 0;
        m_cur    = m_started;
        m_started++;
      end
      if (m_trig && busy_now) m_ovr = 1;
      else if (host_write && host_address == AddrStatus) m_ovr = 0;
      m_trig = host_write && host_address == AddrCtrl && host_writedata[2];
      if (host_write && host_address == AddrCtrl) begin
        m_en  = host_writedata[0];
        m_clr = host_writedata[1];
      end
      if (host_write && host_address == AddrPeriod) m_period = host_writedata[23:0];
    end
  end

  // Compare process plus strobe statistics for the hand-computed expectations.
  int  cyc = 0;
  int  last_strobe_cyc = 0;
  int  last_gap = -1;
  int  read_cnt = 0;
  int  write_cnt = 0;
  bit  prev_strobe = 0;

  initial begin : compare
    bit e_rd, e_wr;
    logic [5:0] e_addr;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        e_rd   = m_active && m_off < 64;
        e_wr   = m_active && m_off >= 64;
        e_addr = e_rd ? 6'(m_off) : (e_wr ? 6'((m_off - 64) * 16) : 6'd0);
        checks++;
        if (perf_read !== e_rd || perf_write !== e_wr || perf_writedata !== 32'h0 ||
            ((e_rd || e_wr) && perf_address !== e_addr)) begin
          errors++;
          $display("FAIL perf_bus cyc=%0d got rd=%b wr=%b addr=%h wd=%h want rd=%b wr=%b addr=%h",
                   cyc, perf_read, perf_write, perf_address, perf_writedata, e_rd, e_wr, e_addr);
        end
        if (exp_pend) begin
          exp_pend = 0;
          if (exp_ok) begin
            checks++;
            if (host_readdata !== exp_val) begin
              errors++;
              $display("FAIL host_read cyc=%0d got %h want %h", cyc, host_readdata, exp_val);
            end
          end
        end
        if (perf_read || perf_write) begin
          if (perf_read && perf_address == 6'd0 && !prev_strobe) last_gap = cyc - last_strobe_cyc;
          last_strobe_cyc = cyc;
        end
        prev_strobe = perf_read || perf_write;
        if (perf_read) read_cnt++;
        if (perf_write) write_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic host_rd(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk);
    host_read    = 1'b1;
    host_address = a;
    @(negedge clk);
    host_read = 1'b0;
    d = host_readdata;
  endtask

  task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    host_write     = 1'b1;
    host_address   = a;
    host_writedata = d;
    @(negedge clk);
    host_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d, v0, v63, seq0;
    int torn, n, r;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_perf_read", {31'b0, perf_read}, 32'd0);
    chk("rst_perf_write", {31'b0, perf_write}, 32'd0);
    chk("rst_perf_address", {26'b0, perf_address}, 32'd0);
    chk("rst_host_readdata", host_readdata, 32'd0);
    host_rd(AddrCtrl, d);   chk("rst_ctrl", d, 32'd0);
    host_rd(AddrPeriod, d); chk("rst_period", d, 32'd0);
    host_rd(AddrSeq, d);    chk("rst_seq", d, 32'd0);

    // One-shot trigger sweep.
    read_cnt = 0;
    host_wr(AddrCtrl, 32'h4);
    idle(80);
    chk("trig_read_cycles", 32'(read_cnt), 32'd64);
    host_rd(AddrSeq, d);    chk("trig_seq", d, 32'd1);
    host_rd(7'h2A, d);      chk("trig_snap_2a", d, 32'h0000_102A);
    host_rd(AddrStatus, d); chk("trig_not_busy", d & 32'h3, 32'd0);
    host_rd(AddrCtrl, d);   chk("trig_reads_zero", d, 32'd0);

    // Continuous sampling with clear and PERIOD=100.
    last_gap = -1;
    write_cnt = 0;
    host_wr(AddrPeriod, 32'd100);
    host_wr(AddrCtrl, 32'h3);
    idle(420);
    chk("period100_gap", 32'(last_gap), 32'd102);
    chk("period100_clears_seen", 32'(write_cnt >= 8), 32'd1);
    host_wr(AddrCtrl, 32'h0);
    idle(150);

    // PERIOD=0: single DONE cycle between sweeps; poll for torn samples.
    last_gap = -1;
    host_wr(AddrPeriod, 32'd0);
    host_wr(AddrCtrl, 32'h1);
    idle(300);
    chk("period0_gap", 32'(last_gap), 32'd2);
    torn = 0;
    for (int i = 0; i < 40; i++) begin
      host_rd(7'h00, v0);
      host_rd(7'h3F, v63);
      if (v0[31:16] > v63[31:16]) torn++;
    end
`ifdef PERF_SAMPLER_DBUF_EN
    chk("dbuf_no_torn_pairs", 32'(torn), 32'd0);
`else
    chk("single_bank_torn_seen", 32'(torn > 0), 32'd1);
`endif
    host_wr(AddrCtrl, 32'h0);
    idle(150);

    // TRIG while busy is dropped and sets OVR; STATUS write clears it.
    host_rd(AddrSeq, seq0);
    host_wr(AddrCtrl, 32'h4);
    idle(20);
    host_wr(AddrCtrl, 32'h4);
    idle(100);
    host_rd(AddrSeq, d);    chk("ovr_single_sweep", d - seq0, 32'd1);
    host_rd(AddrStatus, d); chk("ovr_set", d & 32'h2, 32'h2);
    host_wr(AddrStatus, 32'h0);
    host_rd(AddrStatus, d); chk("ovr_cleared", d & 32'h2, 32'h0);

    // EN cleared mid-sweep: the sweep completes, then the sampler goes idle.
    host_rd(AddrSeq, seq0);
    read_cnt = 0;
    host_wr(AddrCtrl, 32'h1);
    n = 0;
    while (!(perf_read && perf_address == 6'd30) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("en_clear_reached_idx30", 32'(n < 200), 32'd1);
    host_wr(AddrCtrl, 32'h0);
    idle(120);
    chk("en_clear_full_sweep", 32'(read_cnt), 32'd64);
    host_rd(AddrSeq, d); chk("en_clear_seq", d - seq0, 32'd1);
    read_cnt  = 0;
    write_cnt = 0;
    idle(50);
    chk("en_clear_quiet", 32'(read_cnt + write_cnt), 32'd0);

    // Randomized host traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        host_rd(7'($urandom_range(0, 127)), d);
      end else if (r < 67) begin
        host_wr(AddrCtrl, 32'($urandom_range(0, 7)));
      end else if (r < 73) begin
        host_wr(AddrPeriod, 32'($urandom_range(0, 30)));
      end else if (r < 78) begin
        host_wr(AddrStatus, $urandom);
      end else if (r < 83) begin
        host_wr((r < 80) ? AddrSeq : 7'($urandom_range(0, 63)), $urandom);
      end else begin
        idle($urandom_range(1, 8));
      end
    end
    host_wr(AddrCtrl, 32'h0);
    idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
